// File: rtl/branch_resolution_unit_if.sv
// Fetch/execute <-> branch resolution unit signal bundle.
//   master : fetch + execute side (drives predictions and resolutions)
//   slave  : branch_resolution_unit (drives recovery and training outputs)
interface branch_resolution_unit_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
);

  // Prediction push from fetch
  logic              pred_valid_in;
  logic              pred_taken_in;
  logic [PC_W-1:0]   pred_pc_in;
  logic [PC_W-1:0]   pred_target_in;

  // Resolution from execute
  logic              res_valid_in;
  logic              res_taken_in;
  logic [PC_W-1:0]   res_target_in;

  // Recovery, training and status
  logic              queue_full_out;
  logic              flush_out;
  logic              redirect_valid_out;
  logic [PC_W-1:0]   redirect_pc_out;
  logic              stall_out;
  logic              update_valid_out;
  logic              update_taken_out;
  logic [CNT_W-1:0]  mispredict_count_out;
  logic              protocol_err_out;

  modport master (
    output pred_valid_in, pred_taken_in, pred_pc_in, pred_target_in,
    output res_valid_in, res_taken_in, res_target_in,
    input  queue_full_out, flush_out, redirect_valid_out, redirect_pc_out,
    input  stall_out, update_valid_out, update_taken_out,
    input  mispredict_count_out, protocol_err_out
  );

  modport slave (
    input  pred_valid_in, pred_taken_in, pred_pc_in, pred_target_in,
    input  res_valid_in, res_taken_in, res_target_in,
    output queue_full_out, flush_out, redirect_valid_out, redirect_pc_out,
    output stall_out, update_valid_out, update_taken_out,
    output mispredict_count_out, protocol_err_out
  );

endinterface

// File: rtl/branch_resolution_unit.sv
// Execute-side branch resolution unit.
// Queues predictions issued at fetch, resolves them in order against the
// actual outcome, and on a mispredict runs a FLUSH -> DRAIN recovery that
// flushes IF/ID, redirects the PC and stalls fetch. Every accepted
// resolution is returned to the predictor as a one-cycle training strobe.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : slave side of branch_resolution_unit_if (prediction push,
//           resolution, flush/redirect/stall, training, counter, error)
module branch_resolution_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  branch_resolution_unit_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  entry_t           mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic             flush_q;
  logic             redirect_valid_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic             stall_q;
  logic             update_valid_q;
  logic             update_taken_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic             full;
  logic             empty;
  logic             is_idle;
  entry_t           head;
  entry_t           push_entry;
  logic             res_acc;
  logic             push_acc;
  logic             res_err;
  logic             push_err;
  logic             mispredict;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic [PC_W-1:0]  fix_pc;

  // Queue status from the extra pointer wrap bit
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign push_entry = '{taken: bus.pred_taken_in, pc: bus.pred_pc_in, target: bus.pred_target_in};

  // Accept/reject decisions; pushes and resolutions are only honoured in IDLE
  always_comb begin
    is_idle  = (state == IDLE);
    res_acc  = is_idle && bus.res_valid_in && !empty;
    res_err  = is_idle && bus.res_valid_in && empty;
    // A same-cycle pop frees the slot, so a push into a full queue is legal then
    push_acc = is_idle && bus.pred_valid_in && (!full || res_acc);
    push_err = is_idle && bus.pred_valid_in && full && !res_acc;

    // Not-taken with matching direction never compares targets
    mispredict = res_acc &&
                 ((bus.res_taken_in != head.taken) ||
                  (bus.res_taken_in && (bus.res_target_in != head.target)));

    wr_ptr_nxt = push_acc ? wr_ptr + (AW+1)'(1) : wr_ptr;
    // A mispredict discards every younger entry, including one pushed this cycle
    if (mispredict) begin
      rd_ptr_nxt = wr_ptr_nxt;
    end else if (res_acc) begin
      rd_ptr_nxt = rd_ptr + (AW+1)'(1);
    end else begin
      rd_ptr_nxt = rd_ptr;
    end

    // Correct fetch address; the +4 wraps naturally at PC_W bits
    fix_pc = bus.res_taken_in ? bus.res_target_in : head.pc + PC_W'(4);
  end

  // Queue storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clock) begin
    if (reset && push_acc) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // Recovery FSM, queue pointers and all registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_q          <= 1'b0;
      update_valid_q   <= 1'b0;
      update_taken_q   <= 1'b0;
      count_q          <= '0;
      err_q            <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      update_valid_q <= res_acc;
      if (res_acc) begin
        update_taken_q <= bus.res_taken_in;
      end
      if (res_err || push_err) begin
        err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (mispredict) begin
            state            <= FLUSH;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            stall_q          <= 1'b1;
            redirect_pc_q    <= fix_pc;
            if (count_q != '1) begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          state            <= DRAIN;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
        end
        DRAIN: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          stall_q          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.queue_full_out       = full;
  assign bus.flush_out            = flush_q;
  assign bus.redirect_valid_out   = redirect_valid_q;
  assign bus.redirect_pc_out      = redirect_pc_q;
  assign bus.stall_out            = stall_q;
  assign bus.update_valid_out     = update_valid_q;
  assign bus.update_taken_out     = update_taken_q;
  assign bus.mispredict_count_out = count_q;
  assign bus.protocol_err_out     = err_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed vector table,
// randomized traffic against a queue-based reference model, and a
// counter saturation sequence.
module tb_branch_resolution_unit;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clock;
  logic reset;

  branch_resolution_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolution_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;

  // Reference model: in-order list of predictions plus recovery phase
  typedef struct {
    logic        t;
    logic [31:0] pc;
    logic [31:0] tg;
  } ment_t;

  ment_t       mq[$];
  int          ph;      // 0 idle, 1 flushing, 2 draining
  logic        e_fl, e_rdv, e_st, e_uv, e_ut, e_err;
  logic [31:0] e_rpc;
  int          e_cnt;

  typedef struct {
    logic        rst, pv, pt;
    logic [31:0] ppc, ptg;
    logic        rv, rt;
    logic [31:0] rtg;
    logic        full, fl, rdv;
    logic [31:0] rpc;
    logic        st, uv, ut;
    int          cnt;
    logic        err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic pv, logic pt, logic [31:0] ppc, logic [31:0] ptg,
                              logic rv, logic rt, logic [31:0] rtg,
                              logic full, logic fl, logic rdv, logic [31:0] rpc,
                              logic st, logic uv, logic ut, int cnt, logic err);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pt = pt; v.ppc = ppc; v.ptg = ptg;
    v.rv = rv; v.rt = rt; v.rtg = rtg;
    v.full = full; v.fl = fl; v.rdv = rdv; v.rpc = rpc;
    v.st = st; v.uv = uv; v.ut = ut; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic rst, input logic pv, input logic pt, input logic [31:0] ppc,
                     input logic [31:0] ptg, input logic rv, input logic rt, input logic [31:0] rtg);
    reset              = rst;
    bus.pred_valid_in  = pv;
    bus.pred_taken_in  = pt;
    bus.pred_pc_in     = ppc;
    bus.pred_target_in = ptg;
    bus.res_valid_in   = rv;
    bus.res_taken_in   = rt;
    bus.res_target_in  = rtg;
  endtask

  // Applies the rules of one clock edge to the model
  task automatic model_update();
    ment_t h;
    logic  mis;
    if (!reset) begin
      mq.delete();
      ph = 0;
      e_fl = 0; e_rdv = 0; e_st = 0; e_uv = 0; e_ut = 0; e_err = 0;
      e_rpc = 0; e_cnt = 0;
      return;
    end
    e_uv = 0; e_fl = 0; e_rdv = 0;
    if (ph == 1) begin
      ph = 2;
    end else if (ph == 2) begin
      ph = 0;
      e_st = 0;
    end else begin
      mis = 0;
      h.t = 0; h.pc = 0; h.tg = 0;
      if (bus.res_valid_in) begin
        if (mq.size() == 0) begin
          e_err = 1;
        end else begin
          h = mq.pop_front();
          e_uv = 1;
          e_ut = bus.res_taken_in;
          mis = (bus.res_taken_in != h.t) || (bus.res_taken_in && bus.res_target_in != h.tg);
        end
      end
      if (bus.pred_valid_in) begin
        if (mq.size() < DEPTH) mq.push_back('{bus.pred_taken_in, bus.pred_pc_in, bus.pred_target_in});
        else e_err = 1;
      end
      if (mis) begin
        mq.delete();
        ph = 1;
        e_fl = 1; e_rdv = 1; e_st = 1;
        e_rpc = bus.res_taken_in ? bus.res_target_in : h.pc + 32'd4;
        if (e_cnt < CNT_MAX) e_cnt++;
      end
    end
  endtask

  task automatic model_compare();
    chk("m_full",  32'(bus.queue_full_out), 32'(mq.size() == DEPTH));
    chk("m_flush", 32'(bus.flush_out), 32'(e_fl));
    chk("m_rdv",   32'(bus.redirect_valid_out), 32'(e_rdv));
    chk("m_rpc",   bus.redirect_pc_out, e_rpc);
    chk("m_stall", 32'(bus.stall_out), 32'(e_st));
    chk("m_updv",  32'(bus.update_valid_out), 32'(e_uv));
    chk("m_updt",  32'(bus.update_taken_out), 32'(e_ut));
    chk("m_cnt",   32'(bus.mispredict_count_out), 32'(e_cnt));
    chk("m_err",   32'(bus.protocol_err_out), 32'(e_err));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    model_compare();
  endtask

  initial begin
    vec_t v;
    tests = 0;
    fails = 0;
    ph = 0;
    e_fl = 0; e_rdv = 0; e_st = 0; e_uv = 0; e_ut = 0; e_err = 0; e_rpc = 0; e_cnt = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with activity, correct not-taken, direction mispredict, empty resolve
    vt.push_back(mk(0,1,1,'h10,'h20,1,1,'h20,     0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1,'h10,'h20,1,1,'h20,     0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1,0,'h100,0,0,0,0,          0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,1,0,0,              0,0,0,0,0,1,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1,0,'h200,0,0,0,0,          0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,1,1,'h204,'h300,0,0,0,      0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,1,1,'h240,          0,1,1,'h240,1,1,1,1,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,              0,0,0,'h240,1,0,1,1,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,              0,0,0,'h240,0,0,1,1,0));
    vt.push_back(mk(1,0,0,0,0,1,0,0,              0,0,0,'h240,0,0,1,1,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0));
    // Target mispredict with recovery overlap, then not-taken wrap redirect
    vt.push_back(mk(1,1,1,'h400,'h500,0,0,0,      0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,1,1,'h520,          0,1,1,'h520,1,1,1,1,0));
    vt.push_back(mk(1,1,1,'h600,'h700,1,0,0,      0,0,0,'h520,1,0,1,1,0));
    vt.push_back(mk(1,1,1,'h600,'h700,1,0,0,      0,0,0,'h520,0,0,1,1,0));
    vt.push_back(mk(1,1,1,'hFFFFFFFC,'h10,0,0,0,  0,0,0,'h520,0,0,1,1,0));
    vt.push_back(mk(1,0,0,0,0,1,0,0,              0,1,1,0,1,1,0,2,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,              0,0,0,0,1,0,0,2,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,2,0));
    // Fill, overflow, push+pop while full, drain, empty resolve
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1,1,0,32'h1000 + 32'(4*i),0,0,0,0, 0,0,0,0,0,0,0,2,0));
    vt.push_back(mk(1,1,0,'h100C,0,0,0,0,         1,0,0,0,0,0,0,2,0));
    vt.push_back(mk(1,1,0,'h2000,0,0,0,0,         1,0,0,0,0,0,0,2,1));
    vt.push_back(mk(1,1,1,'h3000,'h3100,1,0,0,    1,0,0,0,0,1,0,2,1));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1,0,0,0,0,1,0,0,            0,0,0,0,0,1,0,2,1));
    vt.push_back(mk(1,0,0,0,0,1,1,'h3100,         0,0,0,0,0,1,1,2,1));
    vt.push_back(mk(1,0,0,0,0,1,1,0,              0,0,0,0,0,0,1,2,1));

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      drv(v.rst, v.pv, v.pt, v.ppc, v.ptg, v.rv, v.rt, v.rtg);
      step();
      chk($sformatf("v%0d_full", i),  32'(bus.queue_full_out), 32'(v.full));
      chk($sformatf("v%0d_flush", i), 32'(bus.flush_out), 32'(v.fl));
      chk($sformatf("v%0d_rdv", i),   32'(bus.redirect_valid_out), 32'(v.rdv));
      chk($sformatf("v%0d_rpc", i),   bus.redirect_pc_out, v.rpc);
      chk($sformatf("v%0d_stall", i), 32'(bus.stall_out), 32'(v.st));
      chk($sformatf("v%0d_updv", i),  32'(bus.update_valid_out), 32'(v.uv));
      chk($sformatf("v%0d_updt", i),  32'(bus.update_taken_out), 32'(v.ut));
      chk($sformatf("v%0d_cnt", i),   32'(bus.mispredict_count_out), 32'(v.cnt));
      chk($sformatf("v%0d_err", i),   32'(bus.protocol_err_out), 32'(v.err));
    end

    // Random traffic; small target sets so both hits and misses occur
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ptg, rtg;
      ptg = ($urandom_range(0, 1) != 0) ? 32'h800 : 32'h900;
      rtg = ($urandom_range(0, 1) != 0) ? 32'h800 : 32'h900;
      drv(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {22'($urandom_range(0, 1023)), 10'h0} | 32'(4 * $urandom_range(0, 255)), ptg,
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), rtg);
      step();
    end

    // Forced repeated mispredicts until the counter saturates
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      drv(1, 1, 0, 32'(i * 4), 0, 0, 0, 0);
      step();
      drv(1, 0, 0, 0, 0, 1, 1, 32'h80);
      step();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
    end
    chk("sat_cnt", 32'(bus.mispredict_count_out), 32'(CNT_MAX));
    chk("sat_err", 32'(bus.protocol_err_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
Execute-stage counterpart to the fetch-side 2-bit branch predictor.
- Queues each prediction issued at fetch.
- Resolves queued predictions in order against the actual outcome from execute.
- On a misprediction, drives pipeline flush, PC redirect and stall.
- Returns the actual outcome to the predictor as its training input (branch_in) via update_valid_out/update_taken_out.

Parameters:
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
PC_W, 32, program counter width
CNT_W, 16, mispredict counter width

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset)
pred_valid_in  input  1  fetch pushes one predicted branch this cycle
pred_taken_in  input  1  predicted direction (1 = taken)
pred_pc_in  input  PC_W  PC of predicted branch
pred_target_in  input  PC_W  predicted target (valid when taken)
res_valid_in  input  1  execute resolves oldest queued branch this cycle
res_taken_in  input  1  actual direction
res_target_in  input  PC_W  actual taken target
queue_full_out  output  1  queue holds DEPTH entries
flush_out  output  1  flush IF/ID, one-cycle pulse
redirect_valid_out  output  1  load redirect_pc_out into PC, one-cycle pulse
redirect_pc_out  output  PC_W  corrected fetch address
stall_out  output  1  hold fetch during recovery
update_valid_out  output  1  predictor training strobe
update_taken_out  output  1  actual direction to predictor
mispredict_count_out  output  CNT_W  saturating mispredict count
protocol_err_out  output  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0 at a clock edge):
  - Queue emptied; FSM to IDLE.
  - All outputs 0, redirect_pc_out=0, counter=0.
  - Takes effect mid-recovery as well; no pulse survives reset.
- Queue: circular FIFO of {taken, pc, target}; read/write pointers have log2(DEPTH)+1 bits.
  - Full when pointers differ only in the MSB.
  - Empty when pointers are equal.
  - queue_full_out is combinational from the pointers.
- Push (pred_valid_in=1):
  - In IDLE and not full: entry written.
  - When full: entry dropped, protocol_err_out set.
  - In FLUSH or DRAIN: ignored silently, no error.
- Resolution (res_valid_in=1):
  - In IDLE and queue non-empty: compares against the head entry and pops it.
  - When empty: ignored, protocol_err_out set.
  - In FLUSH or DRAIN: ignored.
- Simultaneous push and resolve in IDLE: both occur. Allowed even when full, because the pop frees the slot in the same cycle. The count is unchanged.
- Misprediction test:
  - res_taken_in != head.taken, or
  - both taken and res_target_in != head.target.
  - Not-taken with matching direction: targets are not compared.
- Training: every accepted resolution produces update_valid_out=1 and update_taken_out=res_taken_in on the next cycle, for exactly one cycle, regardless of the outcome.
- FSM states: IDLE, FLUSH, DRAIN.
  - IDLE -> FLUSH on an accepted mispredicting resolution. Registered, so flush appears 1 cycle after res_valid_in.
  - FLUSH, one cycle:
    - flush_out=1, redirect_valid_out=1, stall_out=1.
    - redirect_pc_out = res_target_in if actual taken, else head.pc+4, wrapping modulo 2^PC_W. Latched at resolution.
    - Queue fully cleared; all younger predictions are on the wrong path.
    - mispredict_count_out increments, saturating at 2^CNT_W-1.
  - FLUSH -> DRAIN unconditionally.
  - DRAIN, one cycle: stall_out=1, flush_out=0, redirect_valid_out=0.
  - DRAIN -> IDLE unconditionally.
- Correct predictions: no flush, no stall, no redirect; total latency 0 bubbles.
- redirect_pc_out holds its last value outside FLUSH. Consumers qualify it with redirect_valid_out.
- protocol_err_out clears only on reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with pushes active -> all outputs 0, queue empty; first push after reset=1 is accepted.
- Correct not-taken: push {taken=0, pc=0x100}, next cycle resolve taken=0 -> update_valid_out=1 and update_taken_out=0 one cycle later; flush_out, stall_out, redirect_valid_out all stay 0; counter=0.
- Direction mispredict: push {0, 0x200}, {1, 0x204, 0x300}; resolve taken=1 with target 0x240 ->
  - next cycle flush_out=1, redirect_pc_out=0x240, stall_out=1, counter=1;
  - following cycle stall only;
  - then IDLE with queue empty, so the second entry is discarded.
- Target mispredict: push {1, 0x400, 0x500}; resolve taken=1 with target 0x520 -> flush with redirect_pc_out=0x520. Also push taken, resolve not-taken at pc=0xFFFFFFFC -> redirect_pc_out=0x0 (wrap).
- Full/empty and simultaneous operations, DEPTH=4:
  - 4 pushes -> queue_full_out=1; 5th push dropped and protocol_err_out=1.
  - Push and resolve together while full -> accepted, full stays 1.
  - Resolve on an empty queue -> ignored, error remains sticky.
- Recovery overlap: during FLUSH/DRAIN drive pred_valid_in and res_valid_in -> both ignored, no update pulse, no error; counter saturates at 0xFFFF after forced repeated mispredicts.
